dcache_responder: RTL

- Direct-mapped, write-through, no-write-allocate data cache. Answers the core's data-side port: address [31:2], 4-bit byte write enables, write data, enable, read data, active-low blocking flag.
- Sits between the core's memory stage and a single-beat memory bus (req/ack).
- Read hits complete in zero cycles, with blocking_n held high.
- Read misses and all writes stall the core through blocking_n until the memory transaction finishes.

---
 rtl/dcache_pkg.sv | 24 ++
 rtl/dcache_line_array.sv | 50 +++++
 rtl/dcache_responder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the direct-mapped write-through data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2,
        RESP    = 2'd3
    } state_e;

    localparam int DEFAULT_INDEX_BITS = 6;
    localparam int WORD_ADDR_BITS     = 30;

    typedef struct packed {
        logic [WORD_ADDR_BITS-1:0] addr;
        logic [31:0]               wdata;
        logic [3:0]                wstrb;
    } core_req_t;

    function automatic int tag_width(input int index_bits);
        return WORD_ADDR_BITS - index_bits;
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Valid/tag/data storage: combinational read port, synchronous write port with byte merge.
module dcache_line_array
    import dcache_pkg::*;
#(
    parameter  int INDEX_BITS = DEFAULT_INDEX_BITS,
    localparam int TAG_BITS   = tag_width(INDEX_BITS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [31:0]           rd_data,
    input  logic                  wr_en,
    input  logic                  wr_alloc,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [31:0]           wr_data,
    input  logic [3:0]            wr_strb
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [31:0]         data_q [LINES];

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

    // Only the valid bits are reset; stale tag/data are harmless behind valid=0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            valid_q <= '0;
        else if (wr_en && wr_alloc)
            valid_q[wr_index] <= 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            if (wr_alloc)
                tag_q[wr_index] <= wr_tag;
            for (int b = 0; b < 4; b++)
                if (wr_strb[b])
                    data_q[wr_index][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

endmodule

// File: rtl/dcache_responder.sv
// Data-side cache responder: zero-cycle read hits, stalls the core on misses and write-throughs.
module dcache_responder
    import dcache_pkg::*;
#(
    parameter  int INDEX_BITS = DEFAULT_INDEX_BITS,
    localparam int TAG_BITS   = tag_width(INDEX_BITS)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_enabled_i,
    input  logic [29:0] core_address_i,
    input  logic [3:0]  core_write_en_i,
    input  logic [31:0] core_data_i,
    output logic [31:0] core_data_o,
    output logic        core_blocking_n_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [29:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    state_e    state_q, state_d;
    core_req_t req_q;
    logic [31:0] resp_q;

    logic [29:0]           look_addr;
    logic [INDEX_BITS-1:0] look_index;
    logic [TAG_BITS-1:0]   look_tag;
    logic                  rd_valid;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [31:0]           rd_data;
    logic                  hit;
    logic                  is_store;
    logic                  accept;

    logic        wr_en;
    logic        wr_alloc;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;

    // Outside IDLE the lookup follows the held request, so the write-through hit check uses it.
    assign look_addr  = (state_q == IDLE) ? core_address_i : req_q.addr;
    assign look_index = look_addr[INDEX_BITS-1:0];
    assign look_tag   = look_addr[29:INDEX_BITS];
    assign hit        = rd_valid && (rd_tag == look_tag);
    assign is_store   = |core_write_en_i;
    assign accept     = (state_q == IDLE) && core_enabled_i && (is_store || !hit);

    assign wr_alloc = (state_q == RD_MISS);
    assign wr_en    = mem_ack_i && ((state_q == RD_MISS) || ((state_q == WR_THRU) && hit));
    assign wr_data  = wr_alloc ? mem_rdata_i : req_q.wdata;
    assign wr_strb  = wr_alloc ? 4'hF : req_q.wstrb;

    dcache_line_array #(.INDEX_BITS(INDEX_BITS)) u_lines (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rd_index (look_index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_alloc (wr_alloc),
        .wr_index (req_q.addr[INDEX_BITS-1:0]),
        .wr_tag   (req_q.addr[29:INDEX_BITS]),
        .wr_data  (wr_data),
        .wr_strb  (wr_strb)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = is_store ? WR_THRU : RD_MISS;
            RD_MISS: if (mem_ack_i) state_d = RESP;
            WR_THRU: if (mem_ack_i) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_q  <= '0;
            resp_q <= '0;
        end else begin
            if (accept) begin
                req_q.addr  <= core_address_i;
                req_q.wdata <= core_data_i;
                req_q.wstrb <= core_write_en_i;
            end
            if (mem_ack_i && (state_q == RD_MISS))
                resp_q <= mem_rdata_i;
            else if (mem_ack_i && (state_q == WR_THRU))
                resp_q <= '0;
        end
    end

    always_comb begin
        core_blocking_n_o = 1'b1;
        core_data_o       = '0;
        mem_req_o         = 1'b0;
        mem_we_o          = 1'b0;
        mem_addr_o        = '0;
        mem_wdata_o       = '0;
        mem_wstrb_o       = '0;
        unique case (state_q)
            IDLE: begin
                if (accept)
                    core_blocking_n_o = 1'b0;
                else if (core_enabled_i)
                    core_data_o = rd_data;
            end
            RD_MISS: begin
                core_blocking_n_o = 1'b0;
                mem_req_o         = 1'b1;
                mem_addr_o        = req_q.addr;
            end
            WR_THRU: begin
                core_blocking_n_o = 1'b0;
                mem_req_o         = 1'b1;
                mem_we_o          = 1'b1;
                mem_addr_o        = req_q.addr;
                mem_wdata_o       = req_q.wdata;
                mem_wstrb_o       = req_q.wstrb;
            end
            RESP:    core_data_o = resp_q;
            default: core_blocking_n_o = 1'b1;
        endcase
    end

endmodule
